seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/disp_pkg.sv | 29 ++
 rtl/seg_scan_if.sv | 20 ++
 rtl/char_to_seg.sv | 9 +
 rtl/seg_scan.sv | 74 +++++++
 tb/tb_seg_scan.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared display definitions: character codes, the active-low segment table
// and the captured-digit record used by the scanner and the message sources.
package disp_pkg;

  localparam logic [5:0] CH_E     = 6'd14;
  localparam logic [5:0] CH_L     = 6'd21;
  localparam logic [5:0] CH_O     = 6'd24;
  localparam logic [5:0] CH_S     = 6'd28;
  localparam logic [5:0] CH_BLANK = 6'd36;
  localparam logic [5:0] CH_DASH  = 6'd37;

  // Active-low {g,f,e,d,c,b,a}: 0-9, A-Z, blank, dash, then 26 spare codes shown blank
  localparam logic [6:0] SEG_TABLE [64] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
    7'h42, 7'h09, 7'h4F, 7'h61, 7'h0A, 7'h47, 7'h48, 7'h2B,
    7'h40, 7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07, 7'h41, 7'h63,
    7'h55, 7'h36, 7'h11, 7'h24, 7'h7F, 7'h3F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  typedef struct packed {
    logic       dp;
    logic [5:0] code;
  } digit_t;

endpackage

// File: rtl/seg_scan_if.sv
// Scanner-side bundle: character request/response plus the display drive lines.
interface seg_scan_if;
  logic [5:0] message;
  logic [3:0] dp_mask;
  logic       disp_en;
  logic       ref_sign;
  logic [1:0] refresh;
  logic [3:0] an;
  logic [7:0] seg;

  modport master (
    input  message, dp_mask, disp_en,
    output ref_sign, refresh, an, seg
  );

  modport slave (
    output message, dp_mask, disp_en,
    input  ref_sign, refresh, an, seg
  );
endinterface

// File: rtl/char_to_seg.sv
// Combinational character-code to active-low 7-segment lookup.
module char_to_seg
  import disp_pkg::*;
(
  input  logic [5:0] i_code,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_TABLE[i_code];
endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner: requests one character per slot,
// latches it once the source has settled, and blanks anodes at slot start.
module seg_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.master  bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_refresh;
  logic             r_ref_sign;
  digit_t           r_digit;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;

  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_refresh_nxt;
  digit_t           w_digit_nxt;
  logic [6:0]       w_seg_nxt;
  logic [3:0]       w_an_nxt;

  assign w_wrap        = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_cnt_nxt     = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_refresh_nxt = w_wrap ? r_refresh + 2'd1 : r_refresh;

  // The source answers two cycles after the request, so sample at cnt==2 only
  always_comb begin
    w_digit_nxt = r_digit;
    if (r_cnt == CNT_W'(2)) begin
      w_digit_nxt.dp   = bus.dp_mask[r_refresh];
      w_digit_nxt.code = bus.message;
    end
  end

  char_to_seg u_char_to_seg (
    .i_code (w_digit_nxt.code),
    .o_seg  (w_seg_nxt)
  );

  assign w_an_nxt = (bus.disp_en && (w_cnt_nxt >= CNT_W'(BLANK_CYC)))
                  ? ~(4'b0001 << w_refresh_nxt) : 4'b1111;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_refresh    <= 2'd3;
      r_ref_sign   <= 1'b0;
      r_digit.dp   <= 1'b0;
      r_digit.code <= CH_BLANK;
      r_an         <= 4'b1111;
      r_seg        <= 8'hFF;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_refresh  <= w_refresh_nxt;
      r_ref_sign <= w_wrap;
      r_digit    <= w_digit_nxt;
      r_an       <= w_an_nxt;
      r_seg      <= {~w_digit_nxt.dp, w_seg_nxt};
    end
  end

  assign bus.ref_sign = r_ref_sign;
  assign bus.refresh  = r_refresh;
  assign bus.an       = r_an;
  assign bus.seg      = r_seg;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: slot-level display model checked every cycle, plus
// directed literal checks for reset timing, message latching and blanking.
module tb_seg_scan;
  localparam int SD = 8;
  localparam int BC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if bus();

  seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic       use_src = 1'b0;
  logic [5:0] msg_rnd = 6'd0;
  logic [5:0] src1 = 6'd36;
  logic [5:0] src2 = 6'd36;
  logic [3:0] dpm = 4'd0;
  logic       en = 1'b0;
  logic [5:0] lose [4] = '{6'd14, 6'd28, 6'd24, 6'd21};

  assign bus.message = use_src ? src2 : msg_rnd;
  assign bus.dp_mask = dpm;
  assign bus.disp_en = en;

  // Lose-message source with two register stages of latency
  always @(posedge clk) begin
    src1 <= lose[bus.refresh];
    src2 <= src1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Active-high {g,f,e,d,c,b,a} glyphs
  function automatic logic [6:0] glyph(input logic [5:0] c);
    case (c)
      6'd0: glyph = 7'h3F;  6'd1: glyph = 7'h06;  6'd2: glyph = 7'h5B;  6'd3: glyph = 7'h4F;
      6'd4: glyph = 7'h66;  6'd5: glyph = 7'h6D;  6'd6: glyph = 7'h7D;  6'd7: glyph = 7'h07;
      6'd8: glyph = 7'h7F;  6'd9: glyph = 7'h6F;  6'd10: glyph = 7'h77; 6'd11: glyph = 7'h7C;
      6'd12: glyph = 7'h39; 6'd13: glyph = 7'h5E; 6'd14: glyph = 7'h79; 6'd15: glyph = 7'h71;
      6'd16: glyph = 7'h3D; 6'd17: glyph = 7'h76; 6'd18: glyph = 7'h30; 6'd19: glyph = 7'h1E;
      6'd20: glyph = 7'h75; 6'd21: glyph = 7'h38; 6'd22: glyph = 7'h37; 6'd23: glyph = 7'h54;
      6'd24: glyph = 7'h3F; 6'd25: glyph = 7'h73; 6'd26: glyph = 7'h67; 6'd27: glyph = 7'h50;
      6'd28: glyph = 7'h6D; 6'd29: glyph = 7'h78; 6'd30: glyph = 7'h3E; 6'd31: glyph = 7'h1C;
      6'd32: glyph = 7'h2A; 6'd33: glyph = 7'h49; 6'd34: glyph = 7'h6E; 6'd35: glyph = 7'h5B;
      6'd37: glyph = 7'h40;
      default: glyph = 7'h00;
    endcase
  endfunction

  // Model: t = rising edges since reset release; slot position follows from t
  int         t = 0;
  logic [5:0] cap_code = 6'd36;
  logic       cap_dp = 1'b0;
  logic       en_l = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; cap_code = 6'd36; cap_dp = 1'b0; en_l = 1'b0;
    end else begin
      if (t % SD == 2) begin
        cap_code = bus.message;
        cap_dp   = dpm[(3 + t / SD) % 4];
      end
      en_l = en;
      t++;
    end
  end

  always @(negedge clk) begin
    int        r;
    logic [3:0] e_an;
    r    = (3 + t / SD) % 4;
    e_an = (en_l && (t % SD) >= BC) ? ~(4'b0001 << r) : 4'b1111;
    check("ref_sign", 32'(bus.ref_sign), 32'((t > 0) && (t % SD == 0)));
    check("refresh",  32'(bus.refresh), 32'(r));
    check("an",       32'(bus.an), 32'(e_an));
    check("seg",      32'(bus.seg), 32'({~cap_dp, ~glyph(cap_code)}));
  end

  task automatic wait_pulse(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.ref_sign) break;
      if (n >= 40) begin
        check("pulse_timeout", 32'(n), 32'(0));
        break;
      end
      #1 msg_rnd = 6'($urandom);
    end
  endtask

  task automatic drive_slot(input string nm, input logic [5:0] code, input logic [1:0] e_ref,
                            input logic [7:0] e_seg, input logic [3:0] e_an);
    int n;
    wait_pulse(n);
    check({nm, "_ref"}, 32'(bus.refresh), 32'(e_ref));
    #1 msg_rnd = 6'($urandom);
    @(negedge clk); #1 msg_rnd = 6'($urandom);
    @(negedge clk); #1 msg_rnd = code;
    @(negedge clk);
    check({nm, "_seg"}, 32'(bus.seg), 32'(e_seg));
    check({nm, "_an"},  32'(bus.an), 32'(e_an));
    #1 msg_rnd = 6'($urandom);
  endtask

  logic [7:0] lose_seg [4] = '{8'h86, 8'h92, 8'hC0, 8'hC7};
  logic [3:0] lose_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    int n;
    int pulses;
    repeat (3) @(negedge clk);
    check("rst_ref_sign", 32'(bus.ref_sign), 32'(0));
    check("rst_refresh",  32'(bus.refresh), 32'(3));
    check("rst_an",       32'(bus.an), 32'(4'hF));
    check("rst_seg",      32'(bus.seg), 32'(8'hFF));

    use_src = 1'b1; en = 1'b1; dpm = 4'd0;
    #1 rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_pulse(n);
      check("lose_gap", 32'(n), 32'((s == 0) ? 8 : 5));
      check("lose_ref", 32'(bus.refresh), 32'(s));
      repeat (3) @(negedge clk);
      check("lose_seg", 32'(bus.seg), 32'(lose_seg[s]));
      check("lose_an",  32'(bus.an), 32'(lose_an[s]));
    end

    use_src = 1'b0; dpm = 4'b0100;
    drive_slot("digit5", 6'd5,  2'd0, 8'h92, 4'b1110);
    drive_slot("dash",   6'd37, 2'd1, 8'hBF, 4'b1101);
    drive_slot("dashdp", 6'd37, 2'd2, 8'h3F, 4'b1011);
    drive_slot("code38", 6'd38, 2'd3, 8'hFF, 4'b0111);
    drive_slot("code63", 6'd63, 2'd0, 8'hFF, 4'b1110);

    #1 en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("off_an", 32'(bus.an), 32'(4'hF));
      if (bus.ref_sign) pulses++;
    end
    check("off_pulses", 32'(pulses >= 2), 32'(1));
    #1 en = 1'b1;
    wait_pulse(n);
    repeat (3) @(negedge clk);
    check("resume_an", 32'(bus.an != 4'hF), 32'(1));

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      msg_rnd = 6'($urandom);
      dpm     = 4'($urandom);
      if ($urandom_range(0, 15) == 0) en = ~en;
    end
    en = 1'b1;

    wait_pulse(n);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_an",   32'(bus.an), 32'(4'hF));
    check("midrst_seg",  32'(bus.seg), 32'(8'hFF));
    check("midrst_ref",  32'(bus.ref_sign), 32'(0));
    check("midrst_refr", 32'(bus.refresh), 32'(3));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_pulse(n);
    check("midrst_first", 32'(n), 32'(8));
    check("midrst_first_ref", 32'(bus.refresh), 32'(0));
    wait_pulse(n);
    check("midrst_period", 32'(n), 32'(8));
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
